// File: rtl/receptor_serie_32_if.sv
// Parallel-side and serial-side signal bundle for receptor_serie_32.
// The master drives the serial link and the ACK; the slave is the receiver.
interface receptor_serie_32_if #(
    parameter int WIDTH = 32
);
    logic             ENB;
    logic             START;
    logic             S_IN;
    logic             DIR;
    logic             ACK;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             BUSY;
    logic             OVERRUN;
    logic             PAR_ERR;

    modport master (
        output ENB, START, S_IN, DIR, ACK,
        input  Q, VALID, BUSY, OVERRUN, PAR_ERR
    );

    modport slave (
        input  ENB, START, S_IN, DIR, ACK,
        output Q, VALID, BUSY, OVERRUN, PAR_ERR
    );
endinterface

// File: rtl/receptor_serie_32.sv
// Serial-to-parallel receiver with VALID/ACK handshake and sticky overrun.
// Optional even-parity trailer bit enabled by RECEPTOR_PARIDAD_EN.
//
// state | meaning
// IDLE  | waiting for ENB & START
// RECV  | frame in progress, capturing one bit per ENB edge
module receptor_serie_32 #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    receptor_serie_32_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 2);
`ifdef RECEPTOR_PARIDAD_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dir_q, dir_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             take_start, take_bit, done;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic d, input logic s);
        return d ? {sr[WIDTH-2:0], s} : {s, sr[WIDTH-1:1]};
    endfunction

    assign take_start = bus.ENB & bus.START;
    assign take_bit   = bus.ENB & ~bus.START & (state_q == RECV);
    assign done       = take_bit & (count_q == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (take_start) state_d = RECV;
        else if (done)  state_d = IDLE;
    end

`ifdef RECEPTOR_PARIDAD_EN
    logic par_q, par_d;
    logic par_err_q, par_err_d;
`endif

    always_comb begin
        sr_d      = sr_q;
        q_d       = q_q;
        count_d   = count_q;
        dir_d     = dir_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef RECEPTOR_PARIDAD_EN
        par_d     = par_q;
        par_err_d = par_err_q;
`endif
        // A START always restarts the frame, whether idle or mid-frame.
        if (take_start) begin
            sr_d    = shift_in('0, bus.DIR, bus.S_IN);
            dir_d   = bus.DIR;
            count_d = CW'(1);
`ifdef RECEPTOR_PARIDAD_EN
            par_d   = bus.S_IN;
`endif
        end else if (take_bit) begin
            count_d = done ? '0 : count_q + CW'(1);
`ifdef RECEPTOR_PARIDAD_EN
            par_d   = par_q ^ bus.S_IN;
            if (!done) sr_d = shift_in(sr_q, dir_q, bus.S_IN);
`else
            sr_d    = shift_in(sr_q, dir_q, bus.S_IN);
`endif
        end

        if (done) begin
`ifdef RECEPTOR_PARIDAD_EN
            q_d       = sr_q;
            par_err_d = par_q ^ bus.S_IN;
`else
            q_d       = shift_in(sr_q, dir_q, bus.S_IN);
`endif
            valid_d = 1'b1;
            if (valid_q && !bus.ACK) overrun_d = 1'b1;
        end else if (valid_q && bus.ACK) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_q      <= '0;
            q_q       <= '0;
            count_q   <= '0;
            dir_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            q_q       <= q_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef RECEPTOR_PARIDAD_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_q     <= par_d;
            par_err_q <= par_err_d;
        end
    end
    assign bus.PAR_ERR = par_err_q;
`else
    assign bus.PAR_ERR = 1'b0;
`endif

    always_comb begin
        bus.Q       = q_q;
        bus.VALID   = valid_q;
        bus.BUSY    = (state_q == RECV);
        bus.OVERRUN = overrun_q;
    end
endmodule

// File: tb/tb_receptor_serie_32.sv
// Directed bench for receptor_serie_32; expected words are hand-chosen constants.
module tb_receptor_serie_32;
    localparam int W = 32;
`ifdef RECEPTOR_PARIDAD_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    receptor_serie_32_if #(.WIDTH(W)) bus ();

    receptor_serie_32 #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick(input logic enb, input logic st, input logic sin,
                        input logic d, input logic ack);
        @(negedge clk);
        bus.ENB = enb; bus.START = st; bus.S_IN = sin; bus.DIR = d; bus.ACK = ack;
        @(posedge clk);
        #1;
        bus.ENB = 1'b0; bus.START = 1'b0; bus.ACK = 1'b0;
    endtask

    // Bits lo..hi of a frame; index W is the parity trailer when enabled.
    task automatic send_range(input logic [W-1:0] word, input logic d, input logic par,
                              input int lo, input int hi, input logic ack_hi);
        logic b;
        for (int i = lo; i <= hi; i++) begin
            if (i >= W) b = par;
            else        b = d ? word[W-1-i] : word[i];
            tick(1'b1, i == 0, b, d, ack_hi && (i == hi));
        end
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic d, input logic ack_last);
        send_range(word, d, ^word, 0, NB-1, ack_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ENB = 1'b0; bus.START = 1'b0; bus.S_IN = 1'b0; bus.DIR = 1'b0; bus.ACK = 1'b0;
        #12;
        check("rst_q",       bus.Q,       32'h0);
        check("rst_valid",   bus.VALID,   32'h0);
        check("rst_busy",    bus.BUSY,    32'h0);
        check("rst_overrun", bus.OVERRUN, 32'h0);
        check("rst_parerr",  bus.PAR_ERR, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // MSB-first frame
        send_range(32'hA5A50F3C, 1'b1, ^32'hA5A50F3C, 0, 0, 1'b0);
        check("t1_busy_mid", bus.BUSY, 32'h1);
        send_range(32'hA5A50F3C, 1'b1, ^32'hA5A50F3C, 1, NB-1, 1'b0);
        check("t1_q",       bus.Q,       32'hA5A50F3C);
        check("t1_valid",   bus.VALID,   32'h1);
        check("t1_busy",    bus.BUSY,    32'h0);
        check("t1_overrun", bus.OVERRUN, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_ack", bus.VALID, 32'h0);

        // LSB-first with an ENB gap between bits 10 and 11
        send_range(32'h00000001, 1'b0, 1'b1, 0, 10, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_range(32'h00000001, 1'b0, 1'b1, 11, W-2, 1'b0);
        check("t2_valid_early", bus.VALID, 32'h0);
        check("t2_busy_early",  bus.BUSY,  32'h1);
        send_range(32'h00000001, 1'b0, 1'b1, W-1, NB-1, 1'b0);
        check("t2_q1",     bus.Q,     32'h00000001);
        check("t2_valid1", bus.VALID, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'hDEADBEEF, 1'b0, 1'b0);
        check("t2_q2", bus.Q, 32'hDEADBEEF);

        // back-to-back frames without ACK, then with ACK on completion
        do_reset();
        send_word(32'h11111111, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b0, 1'b0);
        check("t3_q",       bus.Q,       32'h22222222);
        check("t3_valid",   bus.VALID,   32'h1);
        check("t3_overrun", bus.OVERRUN, 32'h1);
        do_reset();
        send_word(32'h11111111, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b0, 1'b1);
        check("t3b_q",       bus.Q,       32'h22222222);
        check("t3b_valid",   bus.VALID,   32'h1);
        check("t3b_overrun", bus.OVERRUN, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // abort with re-START after 12 bits
        send_range(32'hFFFFFFFF, 1'b0, 1'b0, 0, 11, 1'b0);
        check("t4_valid_part", bus.VALID, 32'h0);
        check("t4_q_part",     bus.Q,     32'h22222222);
        send_word(32'h0000FFFF, 1'b1, 1'b0);
        check("t4_q",     bus.Q,     32'h0000FFFF);
        check("t4_valid", bus.VALID, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_single", bus.VALID, 32'h0);

        // async reset at bit 20
        send_range(32'h12345678, 1'b0, ^32'h12345678, 0, 19, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_q",       bus.Q,       32'h0);
        check("t5_valid",   bus.VALID,   32'h0);
        check("t5_busy",    bus.BUSY,    32'h0);
        check("t5_overrun", bus.OVERRUN, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(32'h12345678, 1'b0, 1'b0);
        check("t5_q_after",     bus.Q,     32'h12345678);
        check("t5_valid_after", bus.VALID, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // parity behaviour
`ifdef RECEPTOR_PARIDAD_EN
        send_range(32'h00000003, 1'b0, 1'b0, 0, NB-1, 1'b0);
        check("t6_q3",     bus.Q,       32'h00000003);
        check("t6_perr3",  bus.PAR_ERR, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_range(32'h00000007, 1'b0, 1'b0, 0, NB-1, 1'b0);
        check("t6_q7",     bus.Q,       32'h00000007);
        check("t6_perr7",  bus.PAR_ERR, 32'h1);
`else
        send_range(32'h00000007, 1'b0, 1'b0, 0, W-1, 1'b0);
        check("t6_q7",     bus.Q,       32'h00000007);
        check("t6_valid",  bus.VALID,   32'h1);
        check("t6_perr",   bus.PAR_ERR, 32'h0);
        check("t6_busy",   bus.BUSY,    32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
